// File: rtl/i2s_tx_master_if.sv
// Sample-pair handshake and serial pin bundle between the DSP pipeline, the
// transmitter and the DAC.
interface i2s_tx_master_if #(
   parameter int SAMPLE_WIDTH = 24
);
   logic                           s_valid_in;
   logic                           s_ready_out;
   logic signed [SAMPLE_WIDTH-1:0] pldata_in;
   logic signed [SAMPLE_WIDTH-1:0] prdata_in;
   logic                           sclk_out;
   logic                           lrck_out;
   logic                           sdata_out;
   logic                           underrun_out;

   modport master (
      input  s_valid_in, pldata_in, prdata_in,
      output s_ready_out, sclk_out, lrck_out, sdata_out, underrun_out
   );

   modport slave (
      output s_valid_in, pldata_in, prdata_in,
      input  s_ready_out, sclk_out, lrck_out, sdata_out, underrun_out
   );
endinterface

// File: rtl/i2s_tx_master.sv
// Clock-master I2S / left-justified / right-justified stereo transmitter.
// SCLK and LRCK are divided down from clk_in; pairs arrive through a one-deep buffer.
module i2s_tx_master #(
   parameter int SAMPLE_WIDTH  = 24,
   parameter int SLOT_WIDTH    = 32,
   parameter int SCLK_HALF_DIV = 2,
   parameter int FORMAT        = 0
) (
   input  logic            clk_in,
   input  logic            rstn_in,
   input  logic            en_in,
   i2s_tx_master_if.master bus
);
   localparam int FRAME_BITS = 2 * SLOT_WIDTH;
   localparam int POS_W      = $clog2(FRAME_BITS);
   localparam int DIV_W      = (SCLK_HALF_DIV > 1) ? $clog2(SCLK_HALF_DIV) : 1;
   localparam int OFFSET     = (FORMAT == 0) ? 1 :
                               (FORMAT == 1) ? 0 : SLOT_WIDTH - SAMPLE_WIDTH;
   localparam logic [POS_W-1:0] POS_LAST = POS_W'(FRAME_BITS - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_HALF_DIV - 1);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   generate
      if (SAMPLE_WIDTH < 1 || SAMPLE_WIDTH > SLOT_WIDTH || SCLK_HALF_DIV < 1 ||
          FORMAT < 0 || FORMAT > 2 || (FORMAT == 0 && SAMPLE_WIDTH == SLOT_WIDTH)) begin : g_bad_params
         $error("i2s_tx_master: unsupported parameter combination");
      end
   endgenerate

   // Serial bit for frame position pos_v: slot select, format offset, MSB first.
   function automatic logic slot_bit(
      input logic signed [SAMPLE_WIDTH-1:0] left,
      input logic signed [SAMPLE_WIDTH-1:0] right,
      input logic        [POS_W-1:0]        pos_v
   );
      int                    p;
      int                    q;
      logic [SAMPLE_WIDTH-1:0] word;
      p = int'(pos_v);
      if (p >= SLOT_WIDTH) begin
         q    = p - SLOT_WIDTH;
         word = right;
      end else begin
         q    = p;
         word = left;
      end
      if (q >= OFFSET && q < OFFSET + SAMPLE_WIDTH)
         word = word >> (SAMPLE_WIDTH - 1 - (q - OFFSET));
      else
         word = '0;
      return word[0];
   endfunction

   logic [0:0]       state;
   logic [DIV_W-1:0] div;
   logic [POS_W-1:0] pos;
   logic             sclk_r, lrck_r, sdata_r, underrun_r;
   logic             hold_full, armed;
   logic signed [SAMPLE_WIDTH-1:0] hold_l, hold_r, frame_l, frame_r;

   logic             tick, fall, wrap, start, stop, accept;
   logic [POS_W-1:0] pos_nxt;
   logic             sdata_nxt, lrck_nxt;
   logic signed [SAMPLE_WIDTH-1:0] src_l, src_r;

   always_comb begin
      tick      = (state == RUN) && (div == DIV_LAST);
      fall      = tick && sclk_r;
      wrap      = fall && (pos == POS_LAST);
      start     = en_in && ((state == IDLE) || wrap);
      stop      = wrap && !en_in;
      accept    = bus.s_valid_in && !hold_full;
      pos_nxt   = start ? '0 : pos + POS_W'(1);
      // A frame start without a buffered pair transmits silence.
      src_l     = start ? (hold_full ? hold_l : '0) : frame_l;
      src_r     = start ? (hold_full ? hold_r : '0) : frame_r;
      sdata_nxt = slot_bit(src_l, src_r, pos_nxt);
      lrck_nxt  = (int'(pos_nxt) >= SLOT_WIDTH);
   end

   always_ff @(posedge clk_in or negedge rstn_in) begin
      if (!rstn_in) begin
         state      <= IDLE;
         div        <= '0;
         pos        <= '0;
         sclk_r     <= 1'b0;
         lrck_r     <= 1'b0;
         sdata_r    <= 1'b0;
         underrun_r <= 1'b0;
         hold_full  <= 1'b0;
         armed      <= 1'b0;
      end else begin
         underrun_r <= start && !hold_full && armed;
         if (start) begin
            state   <= RUN;
            div     <= '0;
            pos     <= '0;
            sclk_r  <= 1'b0;
            lrck_r  <= 1'b0;
            sdata_r <= sdata_nxt;
         end else if (stop) begin
            state   <= IDLE;
            div     <= '0;
            pos     <= '0;
            sclk_r  <= 1'b0;
            lrck_r  <= 1'b0;
            sdata_r <= 1'b0;
         end else if (state == RUN) begin
            if (tick) begin
               div    <= '0;
               sclk_r <= ~sclk_r;
            end else begin
               div <= div + DIV_W'(1);
            end
            if (fall) begin
               pos     <= pos_nxt;
               lrck_r  <= lrck_nxt;
               sdata_r <= sdata_nxt;
            end
         end
         if (stop)
            armed <= 1'b0;
         if (start && hold_full)
            hold_full <= 1'b0;
         // A transfer never coincides with a load: ready is low while full.
         if (accept) begin
            hold_full <= 1'b1;
            armed     <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (accept) begin
         hold_l <= bus.pldata_in;
         hold_r <= bus.prdata_in;
      end
      if (start) begin
         frame_l <= src_l;
         frame_r <= src_r;
      end
   end

   assign bus.s_ready_out  = ~hold_full;
   assign bus.sclk_out     = sclk_r;
   assign bus.lrck_out     = lrck_r;
   assign bus.sdata_out    = sdata_r;
   assign bus.underrun_out = underrun_r;
endmodule

// File: tb/tb_i2s_tx_master.sv
// Bench for i2s_tx_master: three DUTs (I2S, LJ, RJ) share one stimulus and are
// checked every cycle against a frame-time model, plus literal frame words.
module tb_i2s_tx_master;
   localparam int SW    = 24;
   localparam int S     = 32;
   localparam int H     = 2;
   localparam int FRAME = 4 * S * H;
   localparam int LIMIT = 4 * FRAME;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic en = 1'b0;
   logic valid = 1'b0;
   logic signed [SW-1:0] ldata = '0;
   logic signed [SW-1:0] rdata = '0;
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   i2s_tx_master_if #(.SAMPLE_WIDTH(SW)) bus0 ();
   i2s_tx_master_if #(.SAMPLE_WIDTH(SW)) bus1 ();
   i2s_tx_master_if #(.SAMPLE_WIDTH(SW)) bus2 ();

   assign bus0.s_valid_in = valid;
   assign bus0.pldata_in  = ldata;
   assign bus0.prdata_in  = rdata;
   assign bus1.s_valid_in = valid;
   assign bus1.pldata_in  = ldata;
   assign bus1.prdata_in  = rdata;
   assign bus2.s_valid_in = valid;
   assign bus2.pldata_in  = ldata;
   assign bus2.prdata_in  = rdata;

   i2s_tx_master #(.SAMPLE_WIDTH(SW), .SLOT_WIDTH(S), .SCLK_HALF_DIV(H), .FORMAT(0))
      u_i2s (.clk_in(clk), .rstn_in(rstn), .en_in(en), .bus(bus0.master));
   i2s_tx_master #(.SAMPLE_WIDTH(SW), .SLOT_WIDTH(S), .SCLK_HALF_DIV(H), .FORMAT(1))
      u_lj  (.clk_in(clk), .rstn_in(rstn), .en_in(en), .bus(bus1.master));
   i2s_tx_master #(.SAMPLE_WIDTH(SW), .SLOT_WIDTH(S), .SCLK_HALF_DIV(H), .FORMAT(2))
      u_rj  (.clk_in(clk), .rstn_in(rstn), .en_in(en), .bus(bus2.master));

   // Model: m_t is clk cycles since the current frame start.
   logic m_run, m_hfull, m_armed, m_under, m_acc;
   int   m_t;
   logic signed [SW-1:0] m_hl, m_hr, m_fl, m_fr;
   logic m_fs, m_st, m_acc_now;

   assign m_fs      = en && (!m_run || (m_t == FRAME - 1));
   assign m_st      = m_run && (m_t == FRAME - 1) && !en;
   assign m_acc_now = valid && !m_hfull;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_run   <= 1'b0;
         m_t     <= 0;
         m_hfull <= 1'b0;
         m_armed <= 1'b0;
         m_under <= 1'b0;
         m_acc   <= 1'b0;
      end else begin
         m_acc   <= m_acc_now;
         m_under <= m_fs && !m_hfull && m_armed;
         if (m_fs) begin
            m_run <= 1'b1;
            m_t   <= 0;
            m_fl  <= m_hfull ? m_hl : '0;
            m_fr  <= m_hfull ? m_hr : '0;
         end else if (m_st) begin
            m_run <= 1'b0;
            m_t   <= 0;
         end else if (m_run) begin
            m_t <= m_t + 1;
         end
         if (m_acc_now) begin
            m_hl    <= ldata;
            m_hr    <= rdata;
            m_hfull <= 1'b1;
            m_armed <= 1'b1;
         end else begin
            if (m_fs && m_hfull) m_hfull <= 1'b0;
            if (m_st) m_armed <= 1'b0;
         end
      end
   end

   function automatic logic exp_bit(input int fmt, input logic signed [SW-1:0] l,
                                    input logic signed [SW-1:0] r, input int p);
      int d;
      int k;
      logic [SW-1:0] w;
      d = (fmt == 0) ? 1 : (fmt == 1) ? 0 : S - SW;
      k = (p % S) - d;
      w = (p < S) ? l : r;
      if (k < 0 || k >= SW) return 1'b0;
      w = w >> (SW - 1 - k);
      return w[0];
   endfunction

   task automatic chk(input string name, input int idx, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s dut%0d at %0t: got %0h, expected %0h", name, idx, $time, got, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL timeout %s at %0t", name, $time);
   endtask

   task automatic compare_dut(input int f, input logic s, input logic l, input logic d,
                              input logic u, input logic r);
      int p;
      logic e_s, e_l, e_d;
      p   = m_t / (2 * H);
      e_s = m_run && (((m_t / H) % 2) == 1);
      e_l = m_run && (p >= S);
      e_d = m_run && exp_bit(f, m_fl, m_fr, p);
      chk("sclk", f, 64'(s), 64'(e_s));
      chk("lrck", f, 64'(l), 64'(e_l));
      chk("sdata", f, 64'(d), 64'(e_d));
      chk("underrun", f, 64'(u), 64'(m_under));
      chk("ready", f, 64'(r), 64'(!m_hfull));
   endtask

   task automatic wait_accept(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!m_acc && n < LIMIT);
      if (!m_acc) timeout(name);
   endtask

   task automatic wait_t(input int target, input string name);
      int n;
      n = 0;
      while (!(m_run && m_t == target) && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      if (!(m_run && m_t == target)) timeout(name);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (m_run && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      if (m_run) timeout(name);
   endtask

   // Deserialise one frame from each DUT, sampling just after every SCLK rise.
   task automatic capture(output logic [63:0] w0, output logic [63:0] w1,
                          output logic [63:0] w2, output logic [63:0] lr);
      wait_t(0, "frame_start");
      w0 = '0;
      w1 = '0;
      w2 = '0;
      lr = '0;
      for (int c = 0; c < FRAME; c++) begin
         if ((m_t % (2 * H)) == H) begin
            w0 = {w0[62:0], bus0.sdata_out};
            w1 = {w1[62:0], bus1.sdata_out};
            w2 = {w2[62:0], bus2.sdata_out};
            lr = {lr[62:0], bus0.lrck_out};
         end
         @(negedge clk);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_sclk"}, 0, 64'(bus0.sclk_out), 64'h0);
      chk({tag, "_lrck"}, 0, 64'(bus0.lrck_out), 64'h0);
      chk({tag, "_sdata"}, 0, 64'(bus0.sdata_out), 64'h0);
      chk({tag, "_underrun"}, 0, 64'(bus0.underrun_out), 64'h0);
      chk({tag, "_ready"}, 0, 64'(bus0.s_ready_out), 64'h1);
   endtask

   initial begin
      logic [63:0] w0, w1, w2, lr;
      int cnt, idx;
      logic signed [SW-1:0] pl [4];
      logic signed [SW-1:0] pr [4];
      pl = '{24'h111111, 24'h222222, 24'h333333, 24'h444444};
      pr = '{24'hAAAAAA, 24'hBBBBBB, 24'hCCCCCC, 24'hDDDDDD};

      fork
         forever begin
            @(negedge clk);
            compare_dut(0, bus0.sclk_out, bus0.lrck_out, bus0.sdata_out, bus0.underrun_out, bus0.s_ready_out);
            compare_dut(1, bus1.sclk_out, bus1.lrck_out, bus1.sdata_out, bus1.underrun_out, bus1.s_ready_out);
            compare_dut(2, bus2.sclk_out, bus2.lrck_out, bus2.sdata_out, bus2.underrun_out, bus2.s_ready_out);
         end
      join_none

      repeat (3) @(negedge clk);
      chk_reset_vals("por");
      rstn = 1'b1;
      @(negedge clk);

      // Default I2S frame with the reference pair
      ldata = 24'hA5F00F;
      rdata = 24'h5A0FF0;
      valid = 1'b1;
      wait_accept("t1_accept");
      valid = 1'b0;
      en    = 1'b1;
      capture(w0, w1, w2, lr);
      chk("i2s_left", 0, 64'(w0[63:32]), 64'h52F80780);
      chk("i2s_right", 0, 64'(w0[31:0]), 64'h2D07F800);
      chk("lrck_word", 0, lr, 64'h00000000FFFFFFFF);
      en = 1'b0;
      wait_idle("t1_idle");

      // Format offsets with a pair that marks both ends of the sample
      ldata = 24'h800001;
      rdata = 24'h000000;
      valid = 1'b1;
      wait_accept("t2_accept");
      valid = 1'b0;
      en    = 1'b1;
      capture(w0, w1, w2, lr);
      chk("i2s_800001", 0, 64'(w0[63:32]), 64'h40000080);
      chk("lj_800001", 1, 64'(w1[63:32]), 64'h80000100);
      chk("rj_800001", 2, 64'(w2[63:32]), 64'h00800001);
      chk("lj_right_zero", 1, 64'(w1[31:0]), 64'h0);
      en = 1'b0;
      wait_idle("t2_idle");

      // Four pairs streamed with valid held high, then starvation
      ldata = pl[0];
      rdata = pr[0];
      valid = 1'b1;
      wait_accept("t3_accept0");
      idx   = 1;
      ldata = pl[1];
      rdata = pr[1];
      en    = 1'b1;
      cnt   = 0;
      for (int k = 0; k < 6 * FRAME; k++) begin
         @(negedge clk);
         if (m_acc && valid) begin
            idx++;
            if (idx < 4) begin
               ldata = pl[idx];
               rdata = pr[idx];
            end else begin
               valid = 1'b0;
            end
         end
         if (bus0.underrun_out) cnt++;
      end
      chk("stream_accepts", 0, 64'(idx), 64'd4);
      chk("stream_underruns", 0, 64'(cnt), 64'd2);
      en = 1'b0;
      wait_idle("t3_idle");

      // Running with no pair ever supplied: silent, no underrun
      en  = 1'b1;
      cnt = 0;
      for (int k = 0; k < 2 * FRAME; k++) begin
         @(negedge clk);
         if (bus0.underrun_out) cnt++;
         if (bus0.sdata_out || bus1.sdata_out || bus2.sdata_out) cnt++;
      end
      chk("unarmed_quiet", 0, 64'(cnt), 64'd0);
      wait_t(FRAME - 1, "t4_last");
      ldata = 24'h123456;
      rdata = 24'h654321;
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      chk("start_accept_ready", 0, 64'(bus0.s_ready_out), 64'h0);
      chk("start_accept_underrun", 0, 64'(bus0.underrun_out), 64'h0);
      @(negedge clk);
      capture(w0, w1, w2, lr);
      chk("late_left", 0, 64'(w0[63:32]), 64'h091A2B00);
      chk("late_right", 0, 64'(w0[31:0]), 64'h32A19080);

      // Drop enable at p=10 with a pair waiting in the buffer
      ldata = 24'h0F0F0F;
      rdata = 24'h00FF00;
      valid = 1'b1;
      wait_accept("t5_accept");
      valid = 1'b0;
      wait_t(10 * 2 * H, "t5_p10");
      en  = 1'b0;
      cnt = 0;
      for (int k = 0; k < FRAME; k++) begin
         @(negedge clk);
         if (bus0.lrck_out) cnt++;
      end
      chk("drain_lrck_cycles", 0, 64'(cnt), 64'd128);
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus0.sclk_out || bus0.lrck_out || bus0.sdata_out) cnt++;
      end
      chk("idle_outputs", 0, 64'(cnt), 64'd0);
      chk("idle_hold_kept", 0, 64'(bus0.s_ready_out), 64'h0);
      en = 1'b1;
      capture(w0, w1, w2, lr);
      chk("resume_left", 0, 64'(w0[63:32]), 64'h07878780);
      chk("resume_right", 0, 64'(w0[31:0]), 64'h007F8000);

      // Asynchronous reset in the right slot with the buffer full
      ldata = 24'h0A0A0A;
      rdata = 24'h050505;
      valid = 1'b1;
      wait_accept("t6_accept");
      valid = 1'b0;
      wait_t(150, "t6_right_slot");
      #1 rstn = 1'b0;
      #1 chk_reset_vals("async_rst");
      @(negedge clk);
      chk_reset_vals("held_rst");
      rstn  = 1'b1;
      ldata = 24'h7FFFFF;
      rdata = 24'h800000;
      valid = 1'b1;
      wait_accept("t6_post_accept");
      valid = 1'b0;
      capture(w0, w1, w2, lr);
      chk("post_rst_zero", 0, w0, 64'h0);
      chk("post_rst_lrck", 0, lr, 64'h00000000FFFFFFFF);
      capture(w0, w1, w2, lr);
      chk("post_rst_left", 0, 64'(w0[63:32]), 64'h3FFFFF80);
      chk("post_rst_right", 0, 64'(w0[31:0]), 64'h40000000);
      en = 1'b0;
      wait_idle("final_idle");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
